// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive path and its FIFO users.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   typedef struct packed {
      logic       frame_err;
      logic       parity_err;
      logic [7:0] data;
   } rx_word_t;

   localparam int MIN_DIVISOR = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; the head word is visible on pop_data while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign empty    = (level_q == '0);
   assign full     = (level_q == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
   assign level    = level_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8 data bits, optional parity, 1 stop bit, LSB first, with a receive FIFO.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic                          rx,
   input  logic                          cfg_enable,
   input  logic [DIV_WIDTH-1:0]          cfg_divisor,
   input  logic                          cfg_parity_en,
   input  logic                          cfg_parity_odd,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_data,
   output logic                          out_parity_err,
   output logic                          out_frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   input  logic                          clear_overrun,
   output logic                          busy
);

   rx_state_t            state_q;
   logic                 sync1_q;
   logic                 rxs_q;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] div_d;
   logic                 par_en_q;
   logic                 par_odd_q;
   logic [2:0]           idx_q;
   logic [7:0]           shreg_q;
   logic                 perr_q;
   logic                 overrun_q;
   logic                 overrun_d;
   logic                 tick;
   logic                 push;
   logic                 fifo_full;
   logic                 fifo_empty;
   rx_word_t             push_word;
   rx_word_t             head_word;

   assign tick = (cnt_q == '0);
   assign push = cfg_enable && (state_q == STOP) && tick;
   assign push_word = '{frame_err: !rxs_q, parity_err: perr_q, data: shreg_q};

   // Out-of-range divisors are clamped so the start-bit half period never underflows.
   assign div_d = (cfg_divisor < DIV_WIDTH'(MIN_DIVISOR)) ? DIV_WIDTH'(MIN_DIVISOR) : cfg_divisor;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q   <= IDLE;
         sync1_q   <= 1'b1;
         rxs_q     <= 1'b1;
         cnt_q     <= '0;
         div_q     <= DIV_WIDTH'(MIN_DIVISOR);
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         idx_q     <= '0;
         shreg_q   <= '0;
         perr_q    <= 1'b0;
      end else begin
         sync1_q <= rx;
         rxs_q   <= sync1_q;
         if (!cfg_enable) begin
            state_q <= IDLE;
         end else if (state_q == IDLE) begin
            if (!rxs_q) begin
               cnt_q     <= (div_d >> 1) - DIV_WIDTH'(1);
               div_q     <= div_d;
               par_en_q  <= cfg_parity_en;
               par_odd_q <= cfg_parity_odd;
               perr_q    <= 1'b0;
               state_q   <= START;
            end
         end else if (state_q == WAIT_HIGH) begin
            if (rxs_q) state_q <= IDLE;
         end else if (!tick) begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
         end else begin
            cnt_q <= div_q - DIV_WIDTH'(1);
            case (state_q)
               START: begin
                  idx_q   <= '0;
                  state_q <= rxs_q ? IDLE : DATA;
               end
               DATA: begin
                  shreg_q <= {rxs_q, shreg_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= par_en_q ? PARITY : STOP;
               end
               PARITY: begin
                  perr_q  <= rxs_q ^ (^shreg_q) ^ par_odd_q;
                  state_q <= STOP;
               end
               STOP:    state_q <= rxs_q ? IDLE : WAIT_HIGH;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // A drop sets the sticky flag even when a clear arrives in the same cycle.
   always_comb begin
      overrun_d = overrun_q;
      if (push && fifo_full && !(out_valid && out_ready)) overrun_d = 1'b1;
      else if (clear_overrun)                             overrun_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!nreset) overrun_q <= 1'b0;
      else         overrun_q <= overrun_d;
   end

   sync_fifo #(
      .WIDTH ($bits(rx_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .nreset    (nreset),
      .push      (push),
      .push_data (push_word),
      .pop       (out_valid && out_ready),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign out_valid      = !fifo_empty;
   assign out_data       = head_word.data;
   assign out_parity_err = head_word.parity_err;
   assign out_frame_err  = head_word.frame_err;
   assign overrun        = overrun_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames checked against a queue model of the receive FIFO.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          nreset, rx, cfg_enable, cfg_parity_en, cfg_parity_odd;
   logic [15:0]   cfg_divisor;
   logic          out_valid, out_ready, out_parity_err, out_frame_err;
   logic [7:0]    out_data;
   logic [LW-1:0] fifo_level;
   logic          overrun, clear_overrun, busy;

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [9:0] exp_q[$];
   bit         model_ovr;
   bit         clr_until_idle = 1'b0;
   bit         seen_busy = 1'b0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DIV_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .nreset         (nreset),
      .rx             (rx),
      .cfg_enable     (cfg_enable),
      .cfg_divisor    (cfg_divisor),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_parity_err (out_parity_err),
      .out_frame_err  (out_frame_err),
      .fifo_level     (fifo_level),
      .overrun        (overrun),
      .clear_overrun  (clear_overrun),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, landing 1 time unit after the rising edge; optionally release
   // clear_overrun on the first cycle after the frame completes.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (clr_until_idle) begin
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
               clear_overrun  = 1'b0;
               clr_until_idle = 1'b0;
            end
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_level"}, fifo_level, 0);
      chk({tag, "_ovr"},   overrun, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_word"},  {out_frame_err, out_parity_err, out_data}, 0);
   endtask

   // kind: 0 normal, 1 reset at bit abort_at, 2 disable at bit abort_at, 3 leave line low after
   task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                             input int abort_at, input int kind);
      bit   bits[$];
      bit   pbit;
      bit   aborted;
      int   div;
      logic [9:0] w;
      div     = int'(cfg_divisor);
      aborted = 1'b0;
      pbit    = ((($countones(d) % 2) == 1) ^ cfg_parity_odd) ^ flip;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (cfg_parity_en) bits.push_back(pbit);
      bits.push_back(stop);
      for (int i = 0; i < bits.size(); i++) begin
         if (kind == 1 && i == abort_at) begin
            nreset = 1'b0;
            rx     = 1'b1;
            step(2);
            chk_reset_outputs("midreset");
            nreset = 1'b1;
            exp_q.delete();
            model_ovr = 1'b0;
            step(div + 6);
            return;
         end
         if (kind == 2 && i == abort_at) begin
            cfg_enable = 1'b0;
            step(1);
            chk("disable_busy", busy, 0);
            aborted = 1'b1;
         end
         rx = bits[i];
         step(div);
      end
      rx = (kind == 3) ? 1'b0 : 1'b1;
      step(div + 6);
      if (aborted) begin
         cfg_enable = 1'b1;
         step(2);
         return;
      end
      w = {!stop,
           cfg_parity_en && ((($countones(d) + pbit) % 2) != (cfg_parity_odd ? 1 : 0)),
           d};
      if (exp_q.size() == DEPTH) model_ovr = 1'b1;
      else exp_q.push_back(w);
      $display("frame data=%02h flip=%0d stop=%0d div=%0d par_en=%0d odd=%0d level=%0d",
               d, flip, stop, div, cfg_parity_en, cfg_parity_odd, fifo_level);
   endtask

   task automatic drain();
      int         wt;
      logic [9:0] e;
      while (exp_q.size() > 0) begin
         wt = 0;
         while (!out_valid && wt < 200) begin
            step(1);
            wt++;
         end
         chk("drain_valid", out_valid, 1);
         chk("drain_level", fifo_level, exp_q.size());
         e = exp_q.pop_front();
         chk("drain_word", {out_frame_err, out_parity_err, out_data}, e);
         $display("pop word=%03h expected=%03h", {out_frame_err, out_parity_err, out_data}, e);
         out_ready = 1'b1;
         step(1);
         out_ready = 1'b0;
      end
      chk("drained_level", fifo_level, 0);
      chk("drained_valid", out_valid, 0);
   endtask

   initial begin
      nreset = 1'b0; rx = 1'b1; cfg_enable = 1'b1; cfg_divisor = 16'd6;
      cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
      model_ovr = 1'b0;
      step(3);
      chk_reset_outputs("reset");
      nreset = 1'b1;
      step(4);

      // Basic byte, even parity
      send_frame(8'h55, 1'b0, 1'b1, 0, 0);
      chk("basic_level", fifo_level, exp_q.size());
      chk("basic_busy", busy, 0);
      drain();

      // Parity error then a good frame
      send_frame(8'hA3, 1'b1, 1'b1, 0, 0);
      send_frame(8'hA3, 1'b0, 1'b1, 0, 0);
      chk("parity_level", fifo_level, exp_q.size());
      drain();

      // Framing error followed by a long break
      send_frame(8'h7E, 1'b0, 1'b0, 0, 3);
      chk("break_busy0", busy, 1);
      step(30 * int'(cfg_divisor));
      chk("break_busy1", busy, 1);
      chk("break_level", fifo_level, exp_q.size());
      rx = 1'b1;
      step(6);
      chk("break_release", busy, 0);
      drain();

      // Glitch rejection
      cfg_divisor = 16'd8;
      rx = 1'b0; step(2); rx = 1'b1; step(2);
      chk("glitch_start", busy, 1);
      step(20);
      chk("glitch_idle", busy, 0);
      chk("glitch_level", fifo_level, 0);

      // Overrun
      cfg_divisor = 16'd6; cfg_parity_en = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) send_frame(8'(i), 1'b0, 1'b1, 0, 0);
      chk("ovr_level", fifo_level, exp_q.size());
      chk("ovr_flag", overrun, model_ovr);
      drain();
      clear_overrun = 1'b1; step(1); clear_overrun = 1'b0; model_ovr = 1'b0;
      chk("ovr_clear", overrun, model_ovr);
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b1, 0, 0);
      clear_overrun = 1'b1; seen_busy = 1'b0; clr_until_idle = 1'b1;
      send_frame(8'hEE, 1'b0, 1'b1, 0, 0);
      chk("ovr_set_wins", overrun, model_ovr);
      clear_overrun = 1'b1; clr_until_idle = 1'b0; step(1); clear_overrun = 1'b0;
      model_ovr = 1'b0;
      chk("ovr_clear2", overrun, model_ovr);
      drain();

      // Reset during DATA, then a clean frame
      cfg_parity_en = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
      send_frame(8'hF0, 1'b0, 1'b1, 4, 1);
      send_frame(8'hC4, 1'b0, 1'b1, 0, 0);
      drain();

      // Disable mid-frame keeps the FIFO
      send_frame(8'h9B, 1'b0, 1'b1, 0, 0);
      send_frame(8'h00, 1'b0, 1'b1, 3, 2);
      chk("disable_level", fifo_level, exp_q.size());
      drain();

      // Randomized frames
      for (int i = 0; i < 16; i++) begin
         cfg_divisor    = 16'($urandom_range(4, 12));
         cfg_parity_en  = 1'($urandom_range(0, 1));
         cfg_parity_odd = 1'($urandom_range(0, 1));
         send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 0, 0);
         step($urandom_range(0, 5));
         if (i % 4 == 3) drain();
      end
      chk("final_ovr", overrun, model_ovr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
